// File: rtl/change_dispenser.sv
// change_dispenser: greedy 5/3/1 coin payout, one coin per handshake, optional GAP_CYCLES spacing.
// Define DISPENSER_COIN_COUNT_EN to add the coin_count output.
module change_dispenser #(
    parameter int GAP_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_L,
    input  logic       start,
    input  logic [3:0] change,
    input  logic [1:0] Pentagons,
    input  logic [1:0] Triangles,
    input  logic [1:0] Circles,
    output logic       ready,
    output logic       coin_valid,
    output logic [2:0] coin,
    input  logic       coin_ack,
    output logic       done,
    output logic       exact,
    output logic [3:0] remaining,
    output logic [1:0] PentLeft,
    output logic [1:0] TriLeft,
    output logic [1:0] CirLeft
`ifdef DISPENSER_COIN_COUNT_EN
    ,
    output logic [3:0] coin_count
`endif
);
    typedef enum logic [2:0] {IDLE, SELECT, OFFER, GAP, DONE} state_t;
    state_t state, state_nx;
    logic [2:0] coin_r, coin_sel, gap_cnt;
    always_comb begin
        coin_sel = (remaining >= 4'd5 && PentLeft != 2'd0) ? 3'b101 :
                   (remaining >= 4'd3 && TriLeft  != 2'd0) ? 3'b011 :
                   (remaining >= 4'd1 && CirLeft  != 2'd0) ? 3'b001 : 3'b000;
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SELECT : IDLE;
            SELECT:  state_nx = (coin_sel == 3'b000) ? DONE : OFFER;
            OFFER:   state_nx = !coin_ack ? OFFER : (GAP_CYCLES > 0) ? GAP : SELECT;
            GAP:     state_nx = (int'(gap_cnt) >= GAP_CYCLES - 1) ? SELECT : GAP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            coin_r    <= 3'b000;
            gap_cnt   <= 3'd0;
            remaining <= 4'd0;
            PentLeft  <= 2'd0;
            TriLeft   <= 2'd0;
            CirLeft   <= 2'd0;
        end else begin
            state   <= state_nx;
            gap_cnt <= (state == GAP) ? gap_cnt + 3'd1 : 3'd0;
            if (state == IDLE && start) begin
                remaining <= change;
                PentLeft  <= Pentagons;
                TriLeft   <= Triangles;
                CirLeft   <= Circles;
            end
            if (state == SELECT)
                coin_r <= coin_sel;
            // selection guarantees the coin fits and its inventory is nonzero
            if (state == OFFER && coin_ack) begin
                remaining <= remaining - {1'b0, coin_r};
                if (coin_r == 3'b101) PentLeft <= PentLeft - 2'd1;
                if (coin_r == 3'b011) TriLeft  <= TriLeft - 2'd1;
                if (coin_r == 3'b001) CirLeft  <= CirLeft - 2'd1;
            end
        end
    end
`ifdef DISPENSER_COIN_COUNT_EN
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L)
            coin_count <= 4'd0;
        else if (state == IDLE && start)
            coin_count <= 4'd0;
        else if (state == OFFER && coin_ack)
            coin_count <= coin_count + 4'd1;
    end
`endif
    assign ready      = (state == IDLE);
    assign coin_valid = (state == OFFER);
    assign coin       = coin_valid ? coin_r : 3'b000;
    assign done       = (state == DONE);
    assign exact      = done && (remaining == 4'd0);
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Sequential change-payout stage that sits directly downstream of the single-coin selection logic. It accepts a change amount (0-15) and a coin inventory, then repeatedly applies the greedy priority: Pentagon (5), then Triangle (3), then Circle (1). It emits one coin per handshake to the coin-eject mechanism until the change is paid or no usable coin remains. It reports the final remainder and the updated inventory.

Parameters:
GAP_CYCLES, 1, idle cycles inserted after each accepted coin before the next coin is offered (0 = back-to-back); range 0-7

Ports:
clock  input  1  system clock, all state on rising edge
reset_L  input  1  asynchronous active-low reset
start  input  1  request payout; sampled only when ready=1
change  input  4  amount owed, captured on start
Pentagons  input  2  pentagon inventory, captured on start
Triangles  input  2  triangle inventory, captured on start
Circles  input  2  circle inventory, captured on start
ready  output  1  idle, able to accept start
coin_valid  output  1  coin offered on coin
coin  output  3  coin value: 3'b101, 3'b011, 3'b001; 3'b000 when coin_valid=0
coin_ack  input  1  downstream accepts offered coin this cycle
done  output  1  one-cycle pulse at end of payout
exact  output  1  valid with done: 1 iff remaining==0
remaining  output  4  live remainder still owed
PentLeft  output  2  live pentagon inventory
TriLeft  output  2  live triangle inventory
CirLeft  output  2  live circle inventory

Behaviour:
- Reset (async, reset_L=0):
  - state=IDLE; ready=1; coin_valid=0; coin=000; done=0; exact=0.
  - remaining, PentLeft, TriLeft and CirLeft all 0. Gap counter 0.
- IDLE:
  - On start=1, capture change into remaining and the three inventories into the *Left registers. Go to SELECT.
  - ready=0 from the next cycle.
  - start while not IDLE is ignored.
- SELECT (1 cycle), evaluated on the registered values:
  - remaining>=5 and PentLeft>0 → coin=101.
  - Else remaining>=3 and TriLeft>0 → coin=011.
  - Else remaining>=1 and CirLeft>0 → coin=001.
  - Else no coin → go to DONE.
  - If a coin is chosen, register it and go to OFFER.
- OFFER:
  - coin_valid=1, with coin held stable until coin_ack=1.
  - On the ack edge: remaining -= value; the matching *Left register -= 1. coin_valid drops the next cycle.
  - If GAP_CYCLES>0, go to GAP; otherwise go to SELECT.
  - coin_ack while coin_valid=0 is ignored.
- GAP: count GAP_CYCLES cycles, then go to SELECT.
- DONE:
  - done=1 and exact=(remaining==0) for exactly one cycle.
  - Next state is IDLE; ready=1 again the cycle after done.
  - remaining and the *Left registers hold until the next start.
- Per-coin latency with GAP_CYCLES=0: 1 cycle SELECT + at least 1 cycle OFFER. coin_valid first rises 2 cycles after start is sampled.
- Greedy failure is reported, not corrected. Example: change=6, P=1, T=2, C=0 pays 5 and ends with remaining=1, exact=0.
- change=0 goes IDLE→SELECT→DONE with exact=1 and no coin offered.
- Arithmetic:
  - Subtraction never underflows, because selection guards it.
  - All inventory registers are 2 bits; a count of 3 is the maximum and nothing ever increments them.
- Reset mid-offer:
  - Outputs return to reset values immediately, and coin_valid drops asynchronously.
  - An in-flight coin is considered not dispensed.

Optional Feature:
- Macro DISPENSER_COIN_COUNT_EN.
- Defined:
  - Adds output coin_count (4 bits), cleared on start and incremented on each accepted coin.
  - Holds its value after done until the next start. Reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Exact payout, GAP_CYCLES=0, ack tied high: change=9, P=1, T=1, C=1 → coins 101, 011, 001; done with exact=1, remaining=0, Left=0/0/0.
- Greedy shortfall: change=6, P=1, T=2, C=0 → single coin 101; done with exact=0, remaining=1, Left=0/2/0.
- Backpressure: change=3, T=1, coin_ack held low 5 cycles → coin_valid=1 with coin=011 stable for all 5 cycles; remaining stays 3 until ack, then 0.
- Zero / empty: change=0 → done with exact=1 and no coin_valid. Separately, change=4 with all inventories 0 → done with exact=0, remaining=4.
- Gap and restart: GAP_CYCLES=2, change=2, C=3 → two 001 coins separated by exactly 2 idle cycles after the ack. A start pulsed during payout is ignored.
- Async reset: assert reset_L while coin_valid=1 → coin_valid=0 and ready=1 immediately. A new start after release pays normally. With DISPENSER_COIN_COUNT_EN, coin_count=0 after reset and equals the coins paid after done.
